// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and mod-Q normalisation for the toy Kyber decrypt datapath.
package kyber_pkg;

    localparam int Q          = 17;
    localparam int N          = 4;
    localparam int K          = 2;
    localparam int QHALF      = 9;
    localparam int DEC_LO     = 5;
    localparam int DEC_HI     = 12;
    localparam int MAC_CYCLES = K * N * N;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        REDUCE,
        DECODE
    } state_t;

    // Maps any signed value onto 0..q-1, including negative inputs.
    function automatic logic [31:0] mod_q(input logic signed [31:0] x, input int q);
        logic signed [31:0] r;
        r = x % q;
        if (r < 0) begin
            r = r + q;
        end
        return r;
    endfunction

endpackage

// File: rtl/kyber_decrypt_mac.sv
// Sequential negacyclic MAC: one s[k][i]*u[k][j] product per enabled cycle, K*N*N cycles per pass.
// Accumulators are raw two's-complement words; subtraction wraps correctly for the signed result.
module poly_mac_negacyclic
    import kyber_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           en,
    input  logic [K-1:0][N-1:0][CW-1:0]    s,
    input  logic [K-1:0][N-1:0][CW-1:0]    u,
    output logic [N-1:0][31:0]             acc,
    output logic                           last
);

    localparam int IW = $clog2(MAC_CYCLES);
    localparam int NW = $clog2(N);
    localparam int KW = $clog2(K);

    logic [IW-1:0]   idx;
    logic [KW-1:0]   k_idx;
    logic [NW-1:0]   i_idx;
    logic [NW-1:0]   j_idx;
    logic [NW:0]     t;
    logic [2*CW-1:0] prod;

    // idx = {k, i, j}: k outermost, j innermost.
    assign k_idx = idx[2*NW +: KW];
    assign i_idx = idx[NW +: NW];
    assign j_idx = idx[0 +: NW];
    assign t     = {1'b0, i_idx} + {1'b0, j_idx};
    assign prod  = {{CW{1'b0}}, s[k_idx][i_idx]} * {{CW{1'b0}}, u[k_idx][j_idx]};
    assign last  = en && (idx == IW'(MAC_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
        end else if (clear) begin
            idx <= '0;
            acc <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
            // x^N = -1: terms landing at degree >= N fold back negated
            if (t[NW]) begin
                acc[t[NW-1:0]] <= acc[t[NW-1:0]] - 32'(prod);
            end else begin
                acc[t[NW-1:0]] <= acc[t[NW-1:0]] + 32'(prod);
            end
        end
    end

endmodule

// File: rtl/kyber_decrypt.sv
// Toy Kyber decrypt: capture s,u,v -> 32-cycle MAC of s.u -> reduce v-acc -> decode bits.
// done fires 34 cycles after the capturing edge; start is ignored while busy.
module kyber_decrypt #(
    parameter int Q      = kyber_pkg::Q,
    parameter int DEC_LO = kyber_pkg::DEC_LO,
    parameter int DEC_HI = kyber_pkg::DEC_HI
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [1:0][3:0][31:0]  secret_key,
    input  logic signed [1:0][1:0][3:0][31:0] ciphertext,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   message
);
    import kyber_pkg::*;

    localparam int CW = $clog2(Q);

    state_t                       state_q;
    state_t                       state_d;
    logic [K-1:0][N-1:0][CW-1:0]  s_q;
    logic [K-1:0][N-1:0][CW-1:0]  u_q;
    logic [N-1:0][CW-1:0]         v_q;
    logic [N-1:0][CW-1:0]         d_q;
    logic [N-1:0][31:0]           acc;
    logic [N-1:0]                 bits;
    logic                         cap;
    logic                         mac_en;
    logic                         mac_last;
    logic                         unused_ct;

    assign cap       = (state_q == IDLE) && start;
    assign mac_en    = (state_q == MAC);
    assign busy      = (state_q != IDLE);
    assign unused_ct = ^ciphertext[1][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (mac_last) state_d = REDUCE;
            REDUCE:  state_d = DECODE;
            DECODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            u_q <= '0;
            v_q <= '0;
        end else if (cap) begin
            for (int k = 0; k < K; k++) begin
                for (int i = 0; i < N; i++) begin
                    s_q[k][i] <= CW'(mod_q($signed(secret_key[k][i]), Q));
                    u_q[k][i] <= CW'(mod_q($signed(ciphertext[0][k][i]), Q));
                end
            end
            for (int i = 0; i < N; i++) begin
                v_q[i] <= CW'(mod_q($signed(ciphertext[1][0][i]), Q));
            end
        end
    end

    poly_mac_negacyclic #(.CW(CW)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cap),
        .en    (mac_en),
        .s     (s_q),
        .u     (u_q),
        .acc   (acc),
        .last  (mac_last)
    );

    // Bit is 1 when d lies nearer Q/2 than 0 or Q.
    always_comb begin
        bits = '0;
        for (int i = 0; i < N; i++) begin
            bits[i] = (d_q[i] >= CW'(DEC_LO)) && (d_q[i] <= CW'(DEC_HI));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            done    <= 1'b0;
            message <= '0;
        end else begin
            done <= (state_q == DECODE);
            if (state_q == REDUCE) begin
                for (int i = 0; i < N; i++) begin
                    d_q[i] <= CW'(mod_q($signed(32'(v_q[i])) - $signed(acc[i]), Q));
                end
            end
            if (state_q == DECODE) begin
                message <= {{(32-N){1'b0}}, bits};
            end
        end
    end

endmodule
